// File: rtl/clz_seq_ctrl.sv
// Multi-cycle CLZ/CLO sequencer: scans the operand SLICE_W bits per clock from the MSB
// down, stopping at the first set bit, and reports the count through start/busy/done.
module clz_seq_ctrl #(
   parameter int SLICE_W = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        op_clo,
   input  logic [31:0] src,
   input  logic        cancel,
   output logic        busy,
   output logic        done,
   output logic [31:0] result
);

   typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

   state_e             state_q;
   logic [31:0]        sr_q;
   logic [5:0]         cnt_q;
   logic               done_q;
   logic [31:0]        result_q;

   logic [SLICE_W-1:0] top;
   logic [5:0]         idx;
   logic               last;

   assign top  = sr_q[31 -: SLICE_W];
   // Final slice: nothing below it, so an all-zero slice means a full count of 32.
   assign last = (cnt_q == 6'(32 - SLICE_W));

   // Position of the most significant set bit in the slice, counted from its MSB.
   always_comb begin
      idx = '0;
      for (int i = 0; i < SLICE_W; i++) begin
         if (top[i]) idx = 6'(SLICE_W - 1 - i);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= StIdle;
         sr_q     <= '0;
         cnt_q    <= '0;
         done_q   <= 1'b0;
         result_q <= '0;
      end else begin
         done_q <= 1'b0;
         if (cancel) begin
            state_q <= StIdle;
         end else begin
            unique case (state_q)
               StIdle, StDone: begin
                  if (start) begin
                     sr_q    <= op_clo ? ~src : src;
                     cnt_q   <= '0;
                     state_q <= StScan;
                  end else begin
                     state_q <= StIdle;
                  end
               end
               StScan: begin
                  if (top != '0) begin
                     result_q <= {26'd0, cnt_q + idx};
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else if (last) begin
                     result_q <= 32'd32;
                     done_q   <= 1'b1;
                     state_q  <= StDone;
                  end else begin
                     cnt_q <= cnt_q + 6'(SLICE_W);
                     sr_q  <= sr_q << SLICE_W;
                  end
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign busy   = (state_q == StScan);
   assign done   = done_q;
   assign result = result_q;

endmodule

// File: tb/tb_clz_seq_ctrl.sv
// Directed bench for clz_seq_ctrl: table of CLZ/CLO vectors on the SLICE_W=4 instance,
// handshake corner cases, and a slice-width sweep against a reference count.
module tb_clz_seq_ctrl;

   function automatic int sw_of(input int g);
      case (g)
         0:       return 4;
         1:       return 1;
         2:       return 2;
         3:       return 8;
         default: return 32;
      endcase
   endfunction

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  start_v;
   logic        op_clo;
   logic [31:0] src;
   logic        cancel;
   logic        busy_w   [5];
   logic        done_w   [5];
   logic [31:0] result_w [5];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 5; g++) begin : g_dut
      clz_seq_ctrl #(.SLICE_W(sw_of(g))) u_dut (
         .clk    (clk),
         .rst_n  (rst_n),
         .start  (start_v[g]),
         .op_clo (op_clo),
         .src    (src),
         .cancel (cancel),
         .busy   (busy_w[g]),
         .done   (done_w[g]),
         .result (result_w[g])
      );
   end

   typedef struct {
      logic        clo;
      logic [31:0] src;
      int          res;
      int          k;
      string       name;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one request on the SLICE_W=4 instance and check latency, result and hold.
   task automatic run_op(input logic clo, input logic [31:0] s, input int exp_res,
                         input int exp_k, input string name);
      int          scan;
      bit          seen;
      logic [31:0] r;
      op_clo     = clo;
      src        = s;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      scan = 0;
      seen = 0;
      r    = '0;
      for (int t = 0; t < 40 && !seen; t++) begin
         if (done_w[0]) begin
            seen = 1;
            r    = result_w[0];
         end else begin
            if (busy_w[0]) scan++;
            tick();
         end
      end
      check({name, " done"}, 32'(seen), 32'd1);
      check({name, " result"}, r, 32'(exp_res));
      check({name, " scan cycles"}, 32'(scan), 32'(exp_k));
      check({name, " busy at done"}, 32'(busy_w[0]), 32'd0);
      tick();
      check({name, " done width"}, 32'(done_w[0]), 32'd0);
      check({name, " result hold"}, result_w[0], 32'(exp_res));
   endtask

   function automatic int ref_count(input logic clo, input logic [31:0] s);
      logic [31:0] x;
      x = clo ? ~s : s;
      for (int i = 31; i >= 0; i--) begin
         if (x[i]) return 31 - i;
      end
      return 32;
   endfunction

   vec_t vecs[11];

   initial begin
      int          scan;
      int          seen_at [5];
      logic [31:0] res_at  [5];
      logic        clo_r;
      logic [31:0] src_r;
      int          n, k;

      vecs[0]  = '{1'b0, 32'h8000_0000,  0, 1, "clz 80000000"};
      vecs[1]  = '{1'b0, 32'h0000_0000, 32, 8, "clz 00000000"};
      vecs[2]  = '{1'b0, 32'h0000_0001, 31, 8, "clz 00000001"};
      vecs[3]  = '{1'b0, 32'h0010_0000, 11, 3, "clz 00100000"};
      vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 32, 8, "clo ffffffff"};
      vecs[5]  = '{1'b1, 32'hFFF0_0000, 12, 4, "clo fff00000"};
      vecs[6]  = '{1'b1, 32'h7FFF_FFFF,  0, 1, "clo 7fffffff"};
      vecs[7]  = '{1'b0, 32'h0000_FFFF, 16, 5, "clz 0000ffff"};
      vecs[8]  = '{1'b0, 32'h0000_0010, 27, 7, "clz 00000010"};
      vecs[9]  = '{1'b1, 32'hFFFF_FFFE, 31, 8, "clo fffffffe"};
      vecs[10] = '{1'b0, 32'h2000_0000,  2, 1, "clz 20000000"};

      rst_n   = 1'b0;
      start_v = '0;
      op_clo  = 1'b0;
      src     = '0;
      cancel  = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      check("reset busy", 32'(busy_w[0]), 32'd0);
      check("reset done", 32'(done_w[0]), 32'd0);
      check("reset result", result_w[0], 32'd0);

      foreach (vecs[i]) run_op(vecs[i].clo, vecs[i].src, vecs[i].res, vecs[i].k, vecs[i].name);

      // Back-to-back: start held high; the operand changes during SCAN and must be ignored.
      op_clo     = 1'b0;
      src        = 32'h0000_FFFF;
      start_v[0] = 1'b1;
      tick();
      src  = 32'hFFFF_FFFF;
      scan = 0;
      for (int t = 0; t < 40 && !done_w[0]; t++) begin
         if (busy_w[0]) scan++;
         tick();
      end
      check("b2b first done", 32'(done_w[0]), 32'd1);
      check("b2b first result", result_w[0], 32'd16);
      check("b2b first scan cycles", 32'(scan), 32'd5);
      tick();
      start_v[0] = 1'b0;
      check("b2b no idle bubble", 32'(busy_w[0]), 32'd1);
      check("b2b done dropped", 32'(done_w[0]), 32'd0);
      tick();
      check("b2b second done", 32'(done_w[0]), 32'd1);
      check("b2b second result", result_w[0], 32'd0);
      tick();

      // Cancel on the third SCAN cycle of CLZ 0.
      run_op(1'b0, 32'h0010_0000, 11, 3, "pre-cancel");
      op_clo     = 1'b0;
      src        = 32'h0;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      tick();
      tick();
      check("cancel in scan", 32'(busy_w[0]), 32'd1);
      cancel = 1'b1;
      tick();
      cancel = 1'b0;
      check("cancel busy", 32'(busy_w[0]), 32'd0);
      check("cancel done", 32'(done_w[0]), 32'd0);
      check("cancel result", result_w[0], 32'd11);
      seen_at[0] = 0;
      for (int t = 0; t < 10; t++) begin
         if (done_w[0]) seen_at[0] = 1;
         tick();
      end
      check("cancel no late done", 32'(seen_at[0]), 32'd0);

      // Cancel together with start in IDLE drops the request.
      src        = 32'h0000_0001;
      start_v[0] = 1'b1;
      cancel     = 1'b1;
      tick();
      start_v[0] = 1'b0;
      cancel     = 1'b0;
      check("cancel+start busy", 32'(busy_w[0]), 32'd0);
      tick();
      check("cancel+start done", 32'(done_w[0]), 32'd0);
      check("cancel+start result", result_w[0], 32'd11);

      // Reset mid-SCAN.
      src        = 32'h0;
      start_v[0] = 1'b1;
      tick();
      start_v[0] = 1'b0;
      tick();
      check("pre-reset busy", 32'(busy_w[0]), 32'd1);
      rst_n = 1'b0;
      tick();
      check("mid-scan reset busy", 32'(busy_w[0]), 32'd0);
      check("mid-scan reset done", 32'(done_w[0]), 32'd0);
      check("mid-scan reset result", result_w[0], 32'd0);
      rst_n = 1'b1;
      tick();

      // Slice-width sweep on all instances against the reference count.
      for (int v = 0; v < 10; v++) begin
         clo_r = v[0];
         if (v < 2) src_r = 32'h0;
         else src_r = $urandom >> $urandom_range(0, 31);
         if (clo_r) src_r = ~src_r;
         n      = ref_count(clo_r, src_r);
         op_clo = clo_r;
         src    = src_r;
         for (int g = 0; g < 5; g++) begin
            seen_at[g] = 0;
            res_at[g]  = '0;
         end
         start_v = '1;
         tick();
         start_v = '0;
         for (int t = 1; t <= 40; t++) begin
            for (int g = 0; g < 5; g++) begin
               if (seen_at[g] == 0 && done_w[g]) begin
                  seen_at[g] = t;
                  res_at[g]  = result_w[g];
               end
            end
            tick();
         end
         for (int g = 0; g < 5; g++) begin
            k = (n == 32) ? 32 / sw_of(g) : n / sw_of(g) + 1;
            check($sformatf("sweep w%0d src %h clo %0d result", sw_of(g), src_r, clo_r),
                  res_at[g], 32'(n));
            check($sformatf("sweep w%0d src %h clo %0d latency", sw_of(g), src_r, clo_r),
                  32'(seen_at[g]), 32'(k + 1));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
